// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types: transfer/size/response encodings, slave FSM states
// and the little-endian byte-lane helper used by the write path.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      3'd0:    byte_en = 4'b0001 << addr;
      3'd1:    byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_inf_if.sv
// AHB-Lite slave-side signal bundle: the master drives address and write data,
// the slave returns ready, response and read data.
interface ahb_inf_if #(
  parameter int ADDR_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [31:0]       hwdata;
  logic              hready;
  logic [31:0]       hrdata;
  logic              hreadyout;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_mem.sv
// Word-addressed storage: one byte-enabled write port, combinational read of the
// same word, every word cleared by the asynchronous reset.
module ahb_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_inf.sv
// AHB-Lite leaf slave over ahb_mem: WAIT_STATES low-ready cycles per OKAY transfer,
// two-cycle ERROR for out-of-range, oversized or misaligned accesses.
module ahb_inf
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic     hclk,
  input  logic     hresetn,
  ahb_inf_if.slave bus
);

  localparam int              AW        = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_DEPTH * 4);
  localparam logic [3:0]      WS_LOAD   = 4'(WAIT_STATES - 1);

  state_e        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;

  logic          hready_out;
  logic          accept;
  logic          misalign;
  logic          illegal;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;
  logic          unused_bus;

  assign misalign = ((bus.hsize == HSIZE_HALF) && bus.haddr[0]) ||
                    ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));
  assign illegal  = (bus.hsize > HSIZE_WORD) || ({1'b0, bus.haddr} >= MEM_BYTES) || misalign;
  // A new address phase is only taken while this slave is itself showing ready.
  assign accept   = bus.hsel && bus.hready && bus.htrans[1] && hready_out;

  assign unused_bus = ^{bus.hburst, bus.hprot, bus.htrans[0]};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_DATA;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end with ready high, so each may start the next transfer.
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = bus.haddr[AW+1:0];
          write_d = bus.hwrite;
          size_d  = bus.hsize;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WS_LOAD;
          end
        end
      end
    endcase
  end

  always_comb begin
    hready_out = 1'b1;
    bus.hresp  = HRESP_OKAY;
    bus.hrdata = '0;
    mem_we     = 1'b0;
    case (state_q)
      ST_WAIT: hready_out = 1'b0;
      ST_DATA: begin
        mem_we = write_q;
        if (!write_q) begin
          bus.hrdata = mem_rdata;
        end
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        bus.hresp  = HRESP_ERROR;
      end
      ST_ERR2: bus.hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign bus.hreadyout = hready_out;
  assign mem_be        = byte_en(size_q, addr_q[1:0]);

  ahb_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .hclk    (hclk),
    .hresetn (hresetn),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (bus.hwdata),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_inf.sv
// Bench for ahb_inf: a zero-wait and a two-wait instance, a pipelined AHB master,
// a byte-array reference model and a negedge monitor consuming expected responses.
module tb_ahb_inf;

  localparam int         DEPTH  = 256;
  localparam int         LIMIT  = 5000;
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        hsel_a   [2];
  logic [31:0] haddr_a  [2];
  logic [1:0]  htrans_a [2];
  logic        hwrite_a [2];
  logic [2:0]  hsize_a  [2];
  logic [2:0]  hburst_a [2];
  logic [3:0]  hprot_a  [2];
  logic [31:0] hwdata_a [2];
  logic        ryo      [2];
  logic        resp     [2];
  logic [31:0] rdata    [2];

  ahb_inf_if #(.ADDR_W(32)) bus_if [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bus_if[g].hsel   = hsel_a[g];
    assign bus_if[g].haddr  = haddr_a[g];
    assign bus_if[g].htrans = htrans_a[g];
    assign bus_if[g].hwrite = hwrite_a[g];
    assign bus_if[g].hsize  = hsize_a[g];
    assign bus_if[g].hburst = hburst_a[g];
    assign bus_if[g].hprot  = hprot_a[g];
    assign bus_if[g].hwdata = hwdata_a[g];
    assign bus_if[g].hready = bus_if[g].hreadyout;
    assign ryo[g]           = bus_if[g].hreadyout;
    assign resp[g]          = bus_if[g].hresp;
    assign rdata[g]         = bus_if[g].hrdata;

    ahb_inf #(
      .ADDR_W      (32),
      .MEM_DEPTH   (DEPTH),
      .WAIT_STATES (2 * g)
    ) u_dut (
      .hclk    (clk),
      .hresetn (rst_n),
      .bus     (bus_if[g])
    );
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mem_b [2][DEPTH*4];
  req_t        stim_q [$];
  exp_t        exp_q  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH*4; i++) mem_b[b][i] = 8'h00;
  endtask

  // Reference: legality by arithmetic on the byte address, memory as a flat byte array.
  function automatic exp_t model(input int b, input req_t r);
    exp_t e;
    int   nb;
    int   a;
    e.rdata = '0;
    e.err   = (r.size > 3'd2) || (r.addr >= 32'(DEPTH*4));
    nb      = e.err ? 1 : (1 << r.size);
    if ((r.addr % nb) != 0) e.err = 1'b1;
    e.waits = e.err ? 1 : 2 * b;
    if (!e.err) begin
      a = int'(r.addr);
      if (r.write) begin
        for (int k = 0; k < nb; k++) mem_b[b][a+k] = r.wdata[8*((a+k)%4) +: 8];
      end else begin
        for (int k = 0; k < 4; k++) e.rdata[8*k +: 8] = mem_b[b][a - (a % 4) + k];
      end
    end
    return e;
  endfunction

  task automatic add(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                     input logic write, input logic [2:0] size, input logic [31:0] wdata);
    req_t r;
    r = '{sel: sel, trans: trans, addr: addr, write: write, size: size, wdata: wdata};
    stim_q.push_back(r);
  endtask

  task automatic present(input int b, input req_t r);
    hsel_a[b]   = r.sel;
    haddr_a[b]  = r.addr;
    htrans_a[b] = r.trans;
    hwrite_a[b] = r.write;
    hsize_a[b]  = r.size;
    hburst_a[b] = 3'($urandom_range(0, 7));
    hprot_a[b]  = 4'($urandom_range(0, 15));
  endtask

  task automatic present_idle(input int b);
    hsel_a[b]   = 1'b0;
    haddr_a[b]  = '0;
    htrans_a[b] = T_IDLE;
    hwrite_a[b] = 1'b0;
    hsize_a[b]  = 3'd0;
    hburst_a[b] = 3'd0;
    hprot_a[b]  = 4'd0;
  endtask

  // Pipelined master: address phase of the queue head overlaps the data phase of the previous beat.
  task automatic run(input int b);
    req_t dp;
    bit   have_dp = 1'b0;
    bit   pushed  = 1'b0;
    bit   rdy;
    int   budget  = 0;
    dp = '0;
    while ((stim_q.size() > 0 || have_dp) && budget < LIMIT) begin
      if (stim_q.size() > 0) begin
        present(b, stim_q[0]);
        if (!pushed && stim_q[0].sel && stim_q[0].trans[1]) exp_q.push_back(model(b, stim_q[0]));
        pushed = 1'b1;
      end else begin
        present_idle(b);
      end
      hwdata_a[b] = (have_dp && dp.write) ? dp.wdata : $urandom();
      rdy = ryo[b];
      @(posedge clk); #1;
      budget++;
      if (rdy) begin
        have_dp = 1'b0;
        if (stim_q.size() > 0) begin
          if (stim_q[0].sel && stim_q[0].trans[1]) begin
            dp      = stim_q[0];
            have_dp = 1'b1;
          end
          void'(stim_q.pop_front());
          pushed = 1'b0;
        end
      end
    end
    check("run_within_budget", 64'(budget < LIMIT), 64'd1);
    stim_q.delete();
    present_idle(b);
    repeat (2) @(posedge clk);
    #1;
    check("expected_queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic gen_random(input int n);
    req_t r;
    int   pick;
    for (int i = 0; i < n; i++) begin
      r.sel   = ($urandom_range(0, 11) != 0);
      pick    = $urandom_range(0, 9);
      r.trans = (pick == 0) ? T_IDLE : (pick == 1) ? T_BUSY : (pick < 6) ? T_NSEQ : T_SEQ;
      r.write = 1'($urandom_range(0, 1));
      r.size  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r.addr  = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 4) == 0)  r.addr += 32'($urandom_range(0, 3));
      else if (r.size == 3'd0)        r.addr += 32'($urandom_range(0, 3));
      else if (r.size == 3'd1)        r.addr += 32'(2 * $urandom_range(0, 1));
      pick = $urandom_range(0, 19);
      if (pick == 0)      r.addr = 32'(DEPTH*4) + 32'($urandom_range(0, 64) * 4);
      else if (pick == 1) r.addr = 32'(DEPTH*4 - 4);
      r.wdata = $urandom();
      stim_q.push_back(r);
    end
  endtask

  bit   in_dp   [2];
  int   low_cnt [2];
  exp_t cur     [2];

  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!rst_n) begin
        in_dp[b]   = 1'b0;
        low_cnt[b] = 0;
      end else begin
        if (in_dp[b]) begin
          if (!ryo[b]) begin
            low_cnt[b]++;
            check("wait_cycle_hresp", 64'(resp[b]), 64'(cur[b].err));
            check("wait_cycle_hrdata", 64'(rdata[b]), 64'd0);
          end else begin
            check("final_hresp", 64'(resp[b]), 64'(cur[b].err));
            check("final_hrdata", 64'(rdata[b]), 64'(cur[b].rdata));
            check("low_ready_cycles", 64'(low_cnt[b]), 64'(cur[b].waits));
            in_dp[b] = 1'b0;
          end
        end else begin
          check("idle_outputs", {31'd0, ryo[b], resp[b], rdata[b]}, {31'd0, 1'b1, 1'b0, 32'd0});
        end
        if (hsel_a[b] && ryo[b] && htrans_a[b][1]) begin
          check("accept_has_expectation", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            cur[b]     = exp_q.pop_front();
            in_dp[b]   = 1'b1;
            low_cnt[b] = 0;
          end
        end
      end
    end
  end

  initial begin
    req_t r;
    for (int b = 0; b < 2; b++) begin
      present_idle(b);
      hwdata_a[b] = '0;
    end
    clear_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++)
      check("reset_outputs", {31'd0, ryo[b], resp[b], rdata[b]}, {31'd0, 1'b1, 1'b0, 32'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait instance: defaults, round trip, byte lanes, errors, IDLE/BUSY gaps.
    add(1, T_NSEQ, 32'h00, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'h10, 1, 3'd2, 32'hDEADBEEF);
    add(1, T_NSEQ, 32'h10, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'h20, 1, 3'd2, 32'h11223344);
    add(1, T_NSEQ, 32'h21, 1, 3'd0, 32'hAAAAAAAA);
    add(1, T_NSEQ, 32'h20, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'h22, 1, 3'd1, 32'h55665566);
    add(1, T_NSEQ, 32'h20, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'h02, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'(DEPTH*4), 1, 3'd2, 32'hCAFEF00D);
    add(1, T_NSEQ, 32'h00, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'h11, 1, 3'd1, 32'hFFFFFFFF);
    add(1, T_NSEQ, 32'h10, 1, 3'd3, 32'hFFFFFFFF);
    add(1, T_NSEQ, 32'h10, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'h30, 1, 3'd2, 32'hA0A0A0A0);
    add(1, T_BUSY, 32'h34, 1, 3'd2, 32'hBADBAD00);
    add(1, T_SEQ,  32'h34, 1, 3'd2, 32'hA1A1A1A1);
    add(1, T_IDLE, 32'h38, 1, 3'd2, 32'hBADBAD01);
    add(0, T_NSEQ, 32'h38, 1, 3'd2, 32'hBADBAD02);
    add(1, T_NSEQ, 32'h30, 0, 3'd2, 32'h0);
    add(1, T_SEQ,  32'h34, 0, 3'd2, 32'h0);
    add(1, T_SEQ,  32'h38, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'(DEPTH*4-4), 1, 3'd2, 32'h0BADF00D);
    add(1, T_NSEQ, 32'(DEPTH*4-4), 0, 3'd2, 32'h0);
    run(0);
    gen_random(200);
    run(0);

    // Two-wait instance: INCR burst write then read back, error timing.
    add(1, T_NSEQ, 32'h40, 1, 3'd2, 32'd1);
    add(1, T_SEQ,  32'h44, 1, 3'd2, 32'd2);
    add(1, T_SEQ,  32'h48, 1, 3'd2, 32'd3);
    add(1, T_SEQ,  32'h4C, 1, 3'd2, 32'd4);
    add(1, T_NSEQ, 32'h40, 0, 3'd2, 32'h0);
    add(1, T_SEQ,  32'h44, 0, 3'd2, 32'h0);
    add(1, T_SEQ,  32'h48, 0, 3'd2, 32'h0);
    add(1, T_SEQ,  32'h4C, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'h02, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'(DEPTH*4), 1, 3'd2, 32'h12345678);
    add(1, T_NSEQ, 32'h40, 0, 3'd2, 32'h0);
    run(1);

    // Reset pulsed while a write sits in its wait-state data phase.
    r = '{sel: 1'b1, trans: T_NSEQ, addr: 32'h50, write: 1'b1, size: 3'd2, wdata: 32'h12345678};
    present(1, r);
    exp_q.push_back(model(1, r));
    @(posedge clk); #1;
    present_idle(1);
    hwdata_a[1] = r.wdata;
    check("write_data_phase_waiting", 64'(ryo[1]), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {31'd0, ryo[1], resp[1], rdata[1]}, {31'd0, 1'b1, 1'b0, 32'd0});
    clear_model();
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add(1, T_NSEQ, 32'h50, 0, 3'd2, 32'h0);
    add(1, T_NSEQ, 32'h40, 0, 3'd2, 32'h0);
    run(1);
    gen_random(150);
    run(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_inf.md
# ahb_inf

AHB-Lite slave that services single and burst transfers into an on-chip word-addressed memory with byte-lane writes. It has configurable wait states and a two-cycle ERROR response for illegal accesses. It sits behind the AHB decoder/mux as a leaf slave, and is the design under test for the AHB slave verification environment.

## Interface
- ADDR_W, 32, HADDR width.
- MEM_DEPTH, 256, number of 32-bit words; legal byte address range is 0 to MEM_DEPTH*4-1.
- WAIT_STATES, 0, extra data-phase cycles (HREADYOUT low) inserted on every OKAY transfer; range 0–15.

Ports:
- hclk  in  1  clock; all state changes on the rising edge.
- hresetn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select from the decoder.
- haddr  in  ADDR_W  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  0 = byte, 1 = halfword, 2 = word; any value >2 is illegal.
- hburst  in  3  accepted and ignored; every beat carries its own address.
- hprot  in  4  accepted and ignored.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level ready (mux output).
- hrdata  out  32  read data.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.

## Operation
- **Address phase accepted** when hsel=1, hready=1 and htrans[1]=1 (NONSEQ or SEQ), sampled on the rising edge. On acceptance, latch haddr, hwrite and hsize.
- **IDLE or BUSY** (or hsel=0) with hready=1: no data phase; the slave responds OKAY with zero wait.
- **Illegal access**, any one of:
  - address ≥ MEM_DEPTH*4;
  - hsize > 2;
  - misaligned (halfword with haddr[0]=1; word with haddr[1:0]≠0).
- **Illegal response**: two-cycle ERROR (ERR1: hreadyout=0, hresp=1; ERR2: hreadyout=1, hresp=1). No memory update. hrdata=0.
- **Legal write**: after WAIT_STATES cycles with hreadyout=0, one cycle with hreadyout=1. The memory word at latched addr[..:2] is updated on that edge, with byte enables from size and addr[1:0] (little-endian lanes). Unselected lanes are preserved.
- **Legal read**: in the final data cycle, hrdata = mem[latched word address], full 32-bit word with all lanes driven. In all other cycles hrdata = 0.
- **Read after write**: a read whose data phase immediately follows a write data phase to the same word returns the newly written data.
- **State machine**, states IDLE, WAIT, DATA, ERR1, ERR2:
  - IDLE: accept legal → DATA if WAIT_STATES=0, else WAIT; accept illegal → ERR1.
  - WAIT: after WAIT_STATES cycles → DATA.
  - DATA: a new accepted legal or illegal address in the same cycle → next transfer, otherwise IDLE.
  - ERR1 → ERR2.
  - ERR2: same acceptance rules as IDLE.
- An address phase presented while hreadyout=0 is not accepted; the master holds it.

## Timing
- **Reset (asynchronous, hresetn=0)**: hreadyout=1, hresp=0, hrdata=0, state IDLE, all memory words cleared to 0.
- **Reset asserted mid-transfer**: the transfer is aborted, any pending write is discarded, outputs take reset values immediately.
- **Zero-wait latency**: address-phase edge N; data phase is cycle N+1; write commits on edge N+2.
- **Back-to-back pipelining**: one transfer per cycle when WAIT_STATES=0.
- **hresp during waits**: hresp=0 during WAIT and DATA.

## Structure
- Shared package ahb_pkg:
  - htrans, hsize and hresp enums;
  - state enum;
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants;
  - a byte-enable function mapping (hsize, addr[1:0]) to 4 bits.
- Memory as a natural sub-module ahb_mem: single write port with byte enable, asynchronous read, reset clear.
- Control FSM and latching in the top block.

## Test plan
- **Reset defaults**: reset, then word read of 0x0 → hrdata=0x00000000, hresp OKAY, hreadyout=1.
- **Word round trip**: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back → 0xDEADBEEF with zero wait.
- **Byte lanes**: byte write 0xAA @0x21 over word 0x11223344 @0x20 → read @0x20 = 0x1122AA44. Halfword write 0x5566 @0x22 → read = 0x5566AA44.
- **Error cases**: word read @0x2 (misaligned), and write @MEM_DEPTH*4 → hreadyout 0 then 1 with hresp=1 both cycles. The erroneous write leaves memory unchanged.
- **Wait states**: WAIT_STATES=2, 4-beat INCR word burst writes 1,2,3,4 @0x40 then reads → each beat shows 2 cycles of hreadyout=0, and read data is 1,2,3,4.
- **IDLE/BUSY/reset**: IDLE/BUSY inserted mid-burst → OKAY, no memory change. hresetn pulsed low during a write data phase → that write is not committed.
